// File: rtl/decoding_stage_controller_pkg.sv
// rtl/decoding_stage_controller_pkg.sv - stage codes shared by the controller and the PU array
package decoding_stage_controller_pkg;

    localparam int STAGE_WIDTH  = 3;
    localparam int SETTLE_WIDTH = 8;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;

    // True for the stages that make up an active decode (LOADING through PEELING)
    function automatic logic stage_is_working(input logic [STAGE_WIDTH-1:0] stage);
        return (stage == STAGE_MEASUREMENT_LOADING) || (stage == STAGE_GROW) ||
               (stage == STAGE_MERGE) || (stage == STAGE_PEELING);
    endfunction

endpackage

// File: rtl/decoding_stage_controller_settle.sv
// rtl/decoding_stage_controller_settle.sv - per-stage dwell counter gated with aggregated PU busy
module stage_settle_counter
    import decoding_stage_controller_pkg::*;
#(
    parameter int PU_COUNT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [SETTLE_WIDTH-1:0] threshold,
    input  logic [PU_COUNT-1:0]     busy,
    output logic                    settled,
    output logic                    done
);

    logic [SETTLE_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !(&count)) begin
            count <= count + 1'b1;
        end
    end

    // count >= threshold-1, written without underflow for a zero threshold
    assign settled = ({1'b0, count} + 1'b1) >= {1'b0, threshold};
    assign done    = settled && ~|busy;

endmodule

// File: rtl/decoding_stage_controller.sv
// rtl/decoding_stage_controller.sv - union-find stage sequencer; STAGE_CONTROLLER_CYCLE_COUNT_EN enables cycle_count
module decoding_stage_controller
    import decoding_stage_controller_pkg::*;
#(
    parameter int PU_COUNT       = 8,
    parameter int MERGE_SETTLE   = 3,
    parameter int PEEL_SETTLE    = 3,
    parameter int MAX_ITERATIONS = 16,
    parameter int ITER_WIDTH     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PU_COUNT-1:0]    measurements,
    input  logic                   meas_valid,
    output logic                   meas_ready,
    output logic [PU_COUNT-1:0]    measurement_to_pu,
    output logic [STAGE_WIDTH-1:0] global_stage,
    input  logic [PU_COUNT-1:0]    busy,
    input  logic [PU_COUNT-1:0]    odd,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout,
    output logic [31:0]            cycle_count
);

    localparam logic [SETTLE_WIDTH-1:0] MERGE_THRESHOLD = SETTLE_WIDTH'(MERGE_SETTLE);
    localparam logic [SETTLE_WIDTH-1:0] PEEL_THRESHOLD  = SETTLE_WIDTH'(PEEL_SETTLE);
    localparam logic [SETTLE_WIDTH-1:0] HOLD_THRESHOLD  = SETTLE_WIDTH'(2);
    localparam logic [ITER_WIDTH-1:0]   ITER_LIMIT      = ITER_WIDTH'(MAX_ITERATIONS);

    logic [STAGE_WIDTH-1:0]  next_stage;
    logic [SETTLE_WIDTH-1:0] threshold;
    logic                    settled;
    logic                    settle_done;
    logic                    accept;
    logic                    merge_exit_odd;

    assign meas_ready     = (global_stage == STAGE_IDLE);
    assign result_valid   = (global_stage == STAGE_RESULT_VALID);
    assign accept         = meas_valid && meas_ready;
    assign merge_exit_odd = (global_stage == STAGE_MERGE) && settle_done && |odd;

    // LOADING and GROW reuse the counter as a fixed two-cycle hold that ignores busy
    always_comb begin
        threshold = HOLD_THRESHOLD;
        case (global_stage)
            STAGE_MERGE:   threshold = MERGE_THRESHOLD;
            STAGE_PEELING: threshold = PEEL_THRESHOLD;
            default:       threshold = HOLD_THRESHOLD;
        endcase
    end

    stage_settle_counter #(
        .PU_COUNT (PU_COUNT)
    ) u_settle (
        .clk       (clk),
        .reset     (reset),
        .clear     (next_stage != global_stage),
        .enable    (stage_is_working(global_stage)),
        .threshold (threshold),
        .busy      (busy),
        .settled   (settled),
        .done      (settle_done)
    );

    always_comb begin
        next_stage = global_stage;
        case (global_stage)
            STAGE_IDLE: begin
                if (accept) next_stage = STAGE_MEASUREMENT_LOADING;
            end
            STAGE_MEASUREMENT_LOADING, STAGE_GROW: begin
                if (settled) next_stage = STAGE_MERGE;
            end
            STAGE_MERGE: begin
                if (settle_done) begin
                    if (!(|odd))                       next_stage = STAGE_PEELING;
                    else if (iteration_count == ITER_LIMIT) next_stage = STAGE_RESULT_VALID;
                    else                               next_stage = STAGE_GROW;
                end
            end
            STAGE_PEELING: begin
                if (settle_done) next_stage = STAGE_RESULT_VALID;
            end
            STAGE_RESULT_VALID: begin
                if (result_ready) next_stage = STAGE_IDLE;
            end
            default: next_stage = STAGE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            global_stage      <= STAGE_IDLE;
            measurement_to_pu <= '0;
            iteration_count   <= '0;
            timeout           <= 1'b0;
        end else begin
            global_stage <= next_stage;
            if (accept) begin
                measurement_to_pu <= measurements;
                iteration_count   <= '0;
                timeout           <= 1'b0;
            end else if (merge_exit_odd) begin
                if (iteration_count >= ITER_LIMIT) timeout <= 1'b1;
                else                              iteration_count <= iteration_count + 1'b1;
            end
        end
    end

`ifdef STAGE_CONTROLLER_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            cycle_count <= '0;
        end else if (stage_is_working(global_stage) && !(&cycle_count)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_decoding_stage_controller.sv
// tb/tb_decoding_stage_controller.sv - randomized bench for decoding_stage_controller against a stage-trace model
module tb_decoding_stage_controller;
    import decoding_stage_controller_pkg::*;

    localparam int PU       = 8;
    localparam int M_SETTLE = 3;
    localparam int P_SETTLE = 3;
    localparam int MAX_IT   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [PU-1:0]          measurements;
    logic                   meas_valid;
    logic                   meas_ready;
    logic [PU-1:0]          measurement_to_pu;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic [PU-1:0]          busy;
    logic [PU-1:0]          odd;
    logic                   result_valid;
    logic                   result_ready;
    logic [4:0]             iteration_count;
    logic                   timeout;
    logic [31:0]            cycle_count;

    int vectors = 0;
    int miscompares = 0;

    int bl[0:7];
    int pbl;
    int n_odd;
    int hold;
    logic [PU-1:0] meas_word;

    always #5 clk = ~clk;

    decoding_stage_controller #(
        .PU_COUNT       (PU),
        .MERGE_SETTLE   (M_SETTLE),
        .PEEL_SETTLE    (P_SETTLE),
        .MAX_ITERATIONS (MAX_IT),
        .ITER_WIDTH     (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .measurements      (measurements),
        .meas_valid        (meas_valid),
        .meas_ready        (meas_ready),
        .measurement_to_pu (measurement_to_pu),
        .global_stage      (global_stage),
        .busy              (busy),
        .odd               (odd),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .iteration_count   (iteration_count),
        .timeout           (timeout),
        .cycle_count       (cycle_count)
    );

    // Builds the expected stage of every cycle from the decode rules, then drives and checks it
    task automatic run_decode(input string tag);
        logic [STAGE_WIDTH-1:0] exp_q[$];
        logic [PU-1:0] busy_q[$];
        logic [PU-1:0] odd_q[$];
        logic [PU-1:0] odd_k;
        int exp_iter;
        logic exp_to;
        int len;
        int big_l;
        logic [31:0] exp_cc;
        exp_iter = 0;
        exp_to = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(STAGE_MEASUREMENT_LOADING);
            busy_q.push_back(PU'($urandom)); odd_q.push_back(PU'($urandom));
        end
        for (int k = 0; k < 8; k++) begin
            odd_k = (k < n_odd) ? PU'($urandom_range(1, 255)) : '0;
            len = (bl[k] + 1 > M_SETTLE) ? bl[k] + 1 : M_SETTLE;
            for (int j = 0; j < len; j++) begin
                exp_q.push_back(STAGE_MERGE);
                busy_q.push_back((j < bl[k]) ? PU'($urandom_range(1, 255)) : '0);
                odd_q.push_back((j == len - 1) ? odd_k : PU'($urandom));
            end
            if (odd_k == '0) begin
                len = (pbl + 1 > P_SETTLE) ? pbl + 1 : P_SETTLE;
                for (int j = 0; j < len; j++) begin
                    exp_q.push_back(STAGE_PEELING);
                    busy_q.push_back((j < pbl) ? PU'($urandom_range(1, 255)) : '0);
                    odd_q.push_back(PU'($urandom));
                end
                break;
            end
            if (k == MAX_IT) begin
                exp_to = 1'b1;
                break;
            end
            exp_iter++;
            for (int i = 0; i < 2; i++) begin
                exp_q.push_back(STAGE_GROW);
                busy_q.push_back(PU'($urandom)); odd_q.push_back(PU'($urandom));
            end
        end
        exp_q.push_back(STAGE_RESULT_VALID);
        busy_q.push_back(PU'($urandom)); odd_q.push_back(PU'($urandom));
        big_l = exp_q.size();
`ifdef STAGE_CONTROLLER_CYCLE_COUNT_EN
        exp_cc = 32'(big_l - 1);
`else
        exp_cc = 32'd0;
`endif

        @(negedge clk);
        vectors++;
        if (global_stage !== STAGE_IDLE || meas_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_before_accept: stage=%0d ready=%0b expected stage=%0d ready=1", tag, global_stage, meas_ready, STAGE_IDLE);
        end
        meas_valid = 1'b1; measurements = meas_word;
        busy = PU'($urandom); odd = PU'($urandom); result_ready = 1'($urandom);

        for (int t = 1; t <= big_l; t++) begin
            @(negedge clk);
            vectors++;
            if (global_stage !== exp_q[t-1]) begin
                miscompares++;
                $display("FAIL %s stage[t=%0d]: got %0d expected %0d", tag, t, global_stage, exp_q[t-1]);
            end
            vectors++;
            if (measurement_to_pu !== meas_word || meas_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s hold[t=%0d]: meas_to_pu=%0h ready=%0b expected %0h ready=0", tag, t, measurement_to_pu, meas_ready, meas_word);
            end
            vectors++;
            if (result_valid !== (exp_q[t-1] == STAGE_RESULT_VALID)) begin
                miscompares++;
                $display("FAIL %s result_valid[t=%0d]: got %0b expected %0b", tag, t, result_valid, exp_q[t-1] == STAGE_RESULT_VALID);
            end
            meas_valid = 1'($urandom); measurements = PU'($urandom);
            busy = busy_q[t-1]; odd = odd_q[t-1];
            result_ready = (t < big_l) ? 1'($urandom) : (hold == 0);
        end

        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(negedge clk);
                vectors++;
                if (global_stage !== STAGE_RESULT_VALID || result_valid !== 1'b1 || meas_ready !== 1'b0 || measurement_to_pu !== meas_word) begin
                    miscompares++;
                    $display("FAIL %s result_hold[%0d]: stage=%0d valid=%0b ready=%0b m=%0h expected stage=%0d valid=1 ready=0 m=%0h", tag, i, global_stage, result_valid, meas_ready, measurement_to_pu, STAGE_RESULT_VALID, meas_word);
                end
                meas_valid = 1'($urandom); measurements = PU'($urandom);
                busy = PU'($urandom); odd = PU'($urandom);
                result_ready = (i == hold);
            end
            vectors++;
            if (iteration_count !== 5'(exp_iter) || timeout !== exp_to || cycle_count !== exp_cc) begin
                miscompares++;
                $display("FAIL %s result_fields[%0d]: iter=%0d to=%0b cc=%0d expected iter=%0d to=%0b cc=%0d", tag, i, iteration_count, timeout, cycle_count, exp_iter, exp_to, exp_cc);
            end
        end

        @(negedge clk);
        vectors++;
        if (global_stage !== STAGE_IDLE || result_valid !== 1'b0 || meas_ready !== 1'b1 || iteration_count !== 5'(exp_iter)) begin
            miscompares++;
            $display("FAIL %s release: stage=%0d valid=%0b ready=%0b iter=%0d expected stage=%0d valid=0 ready=1 iter=%0d", tag, global_stage, result_valid, meas_ready, iteration_count, STAGE_IDLE, exp_iter);
        end
        meas_valid = 1'b0; result_ready = 1'b0;
    endtask

    task automatic set_sched(input int nodd, input int busy0, input int pb, input int h);
        for (int k = 0; k < 8; k++) bl[k] = 0;
        bl[0] = busy0; n_odd = nodd; pbl = pb; hold = h;
    endtask

    task automatic test_reset();
        reset = 1'b1; meas_valid = 1'b0; result_ready = 1'b0;
        measurements = '0; busy = '0; odd = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (global_stage !== STAGE_IDLE || meas_ready !== 1'b1 || result_valid !== 1'b0 ||
            iteration_count !== 5'd0 || timeout !== 1'b0 || cycle_count !== 32'd0 || measurement_to_pu !== '0) begin
            miscompares++;
            $display("FAIL reset: stage=%0d ready=%0b valid=%0b iter=%0d to=%0b cc=%0d m=%0h expected all idle/zero", global_stage, meas_ready, result_valid, iteration_count, timeout, cycle_count, measurement_to_pu);
        end
    endtask

    task automatic test_empty();
        meas_word = 8'h00; set_sched(0, 0, 0, 0);
        run_decode("empty");
    endtask

    task automatic test_single_grow();
        meas_word = 8'h5a; set_sched(1, 0, 0, 1);
        run_decode("single_grow");
    endtask

    task automatic test_busy_hold();
        meas_word = 8'h04; set_sched(0, 10, 2, 0);
        run_decode("busy_hold");
    endtask

    task automatic test_timeout();
        meas_word = 8'hff; set_sched(MAX_IT + 1, 1, 0, 2);
        run_decode("timeout");
    endtask

    task automatic test_backpressure();
        meas_word = 8'h81; set_sched(2, 0, 1, 5);
        run_decode("backpressure");
    endtask

    task automatic test_reset_mid_merge();
        @(negedge clk);
        meas_valid = 1'b1; measurements = 8'h3c; busy = 8'hff; odd = 8'hff;
        @(negedge clk);
        meas_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (global_stage !== STAGE_MERGE) begin
            miscompares++;
            $display("FAIL mid_merge_entry: stage=%0d expected %0d", global_stage, STAGE_MERGE);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; busy = '0; odd = '0;
        vectors++;
        if (global_stage !== STAGE_IDLE || meas_ready !== 1'b1 || result_valid !== 1'b0 ||
            iteration_count !== 5'd0 || timeout !== 1'b0 || cycle_count !== 32'd0 || measurement_to_pu !== '0) begin
            miscompares++;
            $display("FAIL mid_merge_reset: stage=%0d ready=%0b valid=%0b iter=%0d to=%0b cc=%0d m=%0h expected all idle/zero", global_stage, meas_ready, result_valid, iteration_count, timeout, cycle_count, measurement_to_pu);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            meas_word = PU'($urandom);
            for (int k = 0; k < 8; k++) bl[k] = ($urandom_range(0, 5) == 0) ? 10 : int'($urandom_range(0, 4));
            n_odd = int'($urandom_range(0, MAX_IT + 1));
            pbl = int'($urandom_range(0, 4));
            hold = int'($urandom_range(0, 3));
            run_decode("random");
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_grow();
        test_busy_hold();
        test_timeout();
        test_backpressure();
        test_reset_mid_merge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
